cpu_state_dumper: RTL and testbench
===================================

// Module: cpu_state_dumper
// PURPOSE
//  Synthesizable successor to the end-of-sim register/DMEM dump: on a trigger, freezes the CPU and streams
//  every architectural register, then DMEM words 0..MEM_DEPTH-1, as tagged beats on a valid/ready port.
//  Sits beside cpu; taps the regfile debug read port and a DMEM debug read port. Feeds a UART/trace sink.
//  Adds PC-breakpoint triggering and sink backpressure.
// PARAMETERS
//  WIDTH       12  PC width
//  DATA_WIDTH  16  register / memory word width
//  NUM_REGS     8  registers dumped (power of 2, >=2)
//  MEM_DEPTH   16  DMEM words dumped (power of 2, >=NUM_REGS)
//  REG_AW, MEM_AW: localparams, $clog2 of the above; IDX_W = MEM_AW
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           asynchronous, active-low reset
//  start       in   1           manual trigger pulse
//  pc          in   WIDTH       current CPU PC
//  bp_en       in   1           enable PC-match trigger
//  bp_pc       in   WIDTH       breakpoint PC
//  rf_raddr    out  REG_AW      regfile debug read address (combinational read)
//  rf_rdata    in   DATA_WIDTH  regfile debug read data, same cycle
//  mem_raddr   out  MEM_AW      DMEM debug read address (synchronous read)
//  mem_rdata   in   DATA_WIDTH  DMEM data, valid one cycle after mem_raddr
//  cpu_stall   out  1           freeze PC and pipeline writes
//  dump_valid  out  1           beat valid
//  dump_ready  in   1           sink accepts beat
//  dump_is_mem out  1           0 = register beat, 1 = DMEM beat
//  dump_idx    out  IDX_W       register number / DMEM address (zero-extended)
//  dump_data   out  DATA_WIDTH  word
//  busy        out  1           dump in progress
//  done        out  1           one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, idx 0; all outputs 0. Reset mid-dump aborts, no done pulse.
//  Trigger (IDLE only): start | (bp_en & pc==bp_pc), sampled at posedge. Triggers while busy are ignored.
//  FSM: IDLE -> REG_LD -> REG_OUT -> ... -> MEM_AD -> MEM_LD -> MEM_OUT -> ... -> DONE -> IDLE
//   REG_LD  : rf_raddr=idx; capture rf_rdata, is_mem=0, valid=1 -> REG_OUT
//   REG_OUT : hold beat; on valid&ready: idx==NUM_REGS-1 ? (idx=0, MEM_AD) : (idx++, REG_LD)
//   MEM_AD  : mem_raddr=idx -> MEM_LD
//   MEM_LD  : capture mem_rdata, is_mem=1, valid=1 -> MEM_OUT
//   MEM_OUT : on handshake: idx==MEM_DEPTH-1 ? DONE : (idx++, MEM_AD)
//   DONE    : done=1 for one cycle, cpu_stall=0 -> IDLE
//  cpu_stall and busy: high from the cycle after trigger through the last MEM_OUT; low in IDLE and DONE.
//  Handshake: once dump_valid is high, data/idx/is_mem stay stable until accepted. valid never drops
//   without ready. Beat accepted on the posedge with valid&ready.
//  Throughput: one beat per 2 cycles for registers, one per 3 cycles for DMEM, with ready held high.
//   Total beats = NUM_REGS + MEM_DEPTH.
//  mem_raddr is held at idx through MEM_LD. rf_raddr and mem_raddr are 0 when not in use.
//  Index arithmetic is in IDX_W bits. No wrap occurs because the terminal compare runs before increment.
//  Trigger and reset released in the same cycle: no trigger (reset dominates).
// STRUCTURE
//  Package dbg_pkg: state enum/localparams (IDLE, REG_LD, REG_OUT, MEM_AD, MEM_LD, MEM_OUT, DONE) and
//   DUMP_TAG_REG=0 / DUMP_TAG_MEM=1.
//  Single module. The trigger comparator is inline. One output beat register, one idx counter, FSM.
// TESTING (bench models the regfile as comb array, DMEM as 1-cycle sync RAM)
//  1. regs[i]=16'h1000+i, mem[j]=16'hA000+j, start pulse, ready=1 -> 24 beats: (0,0,1000)..(0,7,1007),
//     then (1,0,A000)..(1,15,A00F). done pulses exactly once, 2*8+3*16+1 cycles after trigger.
//  2. bp_en=1, bp_pc=12'h014, PC stepping by 4 -> trigger the cycle pc==014. cpu_stall rises next
//     cycle; PC frozen at 014 until DONE.
//  3. Random ready (50%) -> beat sequence identical to test 1. Data stable while valid&!ready (assert).
//  4. start pulsed again mid-dump and pc==bp_pc while busy -> ignored; exactly 24 beats, one done.
//  5. reset asserted during MEM_OUT of mem[5] -> all outputs 0 immediately. After release, start -> full
//     24-beat dump from reg 0.
//  6. Parameter sweep NUM_REGS=4, MEM_DEPTH=64, DATA_WIDTH=32 -> 68 beats, last idx 63, then done.

Source files
------------

// File: rtl/cpu_state_dumper_pkg.sv
// Shared definitions for the CPU state dumper: FSM state encoding, beat tags
// and a helper that tells which states freeze the CPU.
package dbg_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REG_LD  = 3'd1,
      REG_OUT = 3'd2,
      MEM_AD  = 3'd3,
      MEM_LD  = 3'd4,
      MEM_OUT = 3'd5,
      DONE    = 3'd6
   } dump_state_e;

   // Tag carried on dump_is_mem: which address space a beat came from.
   localparam logic DUMP_TAG_REG = 1'b0;
   localparam logic DUMP_TAG_MEM = 1'b1;

   // States during which the CPU is frozen and busy is reported.
   function automatic logic is_dump_state(dump_state_e s);
      return (s == REG_LD)  || (s == REG_OUT) || (s == MEM_AD) ||
             (s == MEM_LD)  || (s == MEM_OUT);
   endfunction

endpackage

// File: rtl/cpu_state_dumper_if.sv
// Dump stream port: one tagged beat (register or DMEM word) per valid/ready
// handshake. The dumper drives the master side, the trace/UART sink the slave.
interface cpu_state_dumper_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_W      = 4
);

   logic                  dump_valid;
   logic                  dump_ready;
   logic                  dump_is_mem;
   logic [IDX_W-1:0]      dump_idx;
   logic [DATA_WIDTH-1:0] dump_data;

   modport master (
      output dump_valid,
      output dump_is_mem,
      output dump_idx,
      output dump_data,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_is_mem,
      input  dump_idx,
      input  dump_data,
      output dump_ready
   );

endinterface

// File: rtl/cpu_state_dumper.sv
// CPU state dumper. On a manual start pulse or a PC breakpoint hit (sampled
// only while idle) it freezes the CPU, reads every register through the
// combinational regfile debug port, then every DMEM word through the
// synchronous DMEM debug port, and presents each word as a tagged beat on the
// dump stream. A one-cycle done pulse follows acceptance of the last beat.
module cpu_state_dumper
   import dbg_pkg::*;
#(
   parameter  int WIDTH      = 12,
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_REGS   = 8,
   parameter  int MEM_DEPTH  = 16,
   localparam int REG_AW     = $clog2(NUM_REGS),
   localparam int MEM_AW     = $clog2(MEM_DEPTH),
   localparam int IDX_W      = MEM_AW
) (
   input  logic                  clk,
   input  logic                  reset,      // asynchronous, active-low
   input  logic                  start,
   input  logic [WIDTH-1:0]      pc,
   input  logic                  bp_en,
   input  logic [WIDTH-1:0]      bp_pc,
   output logic [REG_AW-1:0]     rf_raddr,
   input  logic [DATA_WIDTH-1:0] rf_rdata,
   output logic [MEM_AW-1:0]     mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  cpu_stall,
   cpu_state_dumper_if.master    dump,
   output logic                  busy,
   output logic                  done
);

   // Terminal indices; compared before incrementing so idx never wraps.
   localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_DEPTH - 1);

   dump_state_e           state_q,    state_d;
   logic [IDX_W-1:0]      idx_q,      idx_d;
   logic                  valid_q,    valid_d;
   logic                  is_mem_q,   is_mem_d;
   logic [IDX_W-1:0]      beat_idx_q, beat_idx_d;
   logic [DATA_WIDTH-1:0] data_q,     data_d;
   logic                  busy_q,     busy_d;
   logic                  done_q,     done_d;

   logic trigger;
   logic handshake;

   // Manual start or breakpoint hit; only acted upon in IDLE.
   assign trigger   = start | (bp_en & (pc == bp_pc));
   assign handshake = valid_q & dump.dump_ready;

   // Next-state, index and beat-register logic.
   // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      is_mem_d   = is_mem_q;
      beat_idx_d = beat_idx_q;
      data_d     = data_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (trigger) begin
               idx_d   = '0;
               state_d = REG_LD;
            end
         end

         // Register read is combinational: capture in the same cycle.
         REG_LD: begin
            valid_d    = 1'b1;
            is_mem_d   = DUMP_TAG_REG;
            beat_idx_d = idx_q;
            data_d     = rf_rdata;
            state_d    = REG_OUT;
         end

         REG_OUT: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (idx_q == LAST_REG) begin
                  idx_d   = '0;
                  state_d = MEM_AD;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = REG_LD;
               end
            end
         end

         // DMEM read is synchronous: address now, data next cycle.
         MEM_AD: state_d = MEM_LD;

         MEM_LD: begin
            valid_d    = 1'b1;
            is_mem_d   = DUMP_TAG_MEM;
            beat_idx_d = idx_q;
            data_d     = mem_rdata;
            state_d    = MEM_OUT;
         end

         MEM_OUT: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (idx_q == LAST_MEM) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = MEM_AD;
               end
            end
         end

         DONE: state_d = IDLE;

         default: begin
            idx_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Stall/busy are registered copies of "next state is a dump state".
      busy_d = is_dump_state(state_d);
   end

   // State, index, beat and status registers; reset aborts any dump silently.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         is_mem_q   <= 1'b0;
         beat_idx_q <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         is_mem_q   <= is_mem_d;
         beat_idx_q <= beat_idx_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Debug read addresses are driven only while their read is in flight.
   assign rf_raddr  = (state_q == REG_LD) ? idx_q[REG_AW-1:0] : '0;
   assign mem_raddr = ((state_q == MEM_AD) || (state_q == MEM_LD)) ? idx_q[MEM_AW-1:0] : '0;

   assign cpu_stall = busy_q;
   assign busy      = busy_q;
   assign done      = done_q;

   assign dump.dump_valid  = valid_q;
   assign dump.dump_is_mem = is_mem_q;
   assign dump.dump_idx    = beat_idx_q;
   assign dump.dump_data   = data_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Scoreboard bench for cpu_state_dumper. A trigger pushes the full expected
// beat list (all registers, then all DMEM words) into a queue; per-instance
// monitors pop and compare on every accepted beat and check done timing.
module tb_cpu_state_dumper;
   import dbg_pkg::*;

   localparam int A_NR = 8;
   localparam int A_MD = 16;
   localparam int B_NR = 4;
   localparam int B_MD = 64;
   localparam int A_DONE_LAT = 2 * A_NR + 3 * A_MD + 1;
   localparam int B_DONE_LAT = 2 * B_NR + 3 * B_MD + 1;

   typedef struct {
      logic        is_mem;
      int          idx;
      logic [31:0] data;
   } beat_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cycle = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input string msg);
      checks++;
      failures++;
      $display("FAIL %s: %s (t=%0t)", name, msg, $time);
   endtask

   // ---------------- instance A: default parameters ----------------
   logic        start_a = 1'b0, bp_en_a = 1'b0;
   logic [11:0] pc_a, bp_pc_a = '0;
   logic [2:0]  rf_raddr_a;
   logic [15:0] rf_rdata_a, mem_rdata_a;
   logic [3:0]  mem_raddr_a;
   logic        stall_a, busy_a, done_a;
   logic        ready_a = 1'b0, ready_rand_a = 1'b0, ready_hold_a = 1'b1;
   logic        cpu_run = 1'b0, pc_clr = 1'b1;
   logic [15:0] regs_a [A_NR];
   logic [15:0] mem_a  [A_MD];

   cpu_state_dumper_if #(.DATA_WIDTH(16), .IDX_W(4)) if_a ();
   assign if_a.dump_ready = ready_a;

   cpu_state_dumper #(.WIDTH(12), .DATA_WIDTH(16), .NUM_REGS(A_NR), .MEM_DEPTH(A_MD)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .pc(pc_a), .bp_en(bp_en_a), .bp_pc(bp_pc_a),
      .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a), .mem_raddr(mem_raddr_a), .mem_rdata(mem_rdata_a),
      .cpu_stall(stall_a), .dump(if_a), .busy(busy_a), .done(done_a));

   // Regfile: combinational debug read. DMEM: one-cycle synchronous read.
   assign rf_rdata_a = regs_a[rf_raddr_a];
   always @(posedge clk) mem_rdata_a <= mem_a[mem_raddr_a];

   // Tiny CPU: steps PC by 4 unless stalled; halts itself on a breakpoint hit.
   always @(posedge clk)
      if (pc_clr) pc_a <= '0;
      else if (cpu_run && !stall_a && !(bp_en_a && pc_a == bp_pc_a)) pc_a <= pc_a + 12'd4;

   always @(posedge clk) begin
      #1;
      ready_a = ready_rand_a ? 1'($urandom_range(0, 1)) : ready_hold_a;
   end

   beat_t       exp_a [$];
   int          beats_a = 0, dones_a = 0, exp_done_cyc_a = -1;
   logic        hold_pend_a = 1'b0;
   logic [63:0] hold_snap_a = '0;

   task automatic push_expect_a();
      for (int i = 0; i < A_NR; i++) exp_a.push_back('{1'b0, i, 32'(regs_a[i])});
      for (int j = 0; j < A_MD; j++) exp_a.push_back('{1'b1, j, 32'(mem_a[j])});
   endtask

   always @(negedge clk) begin : mon_a
      beat_t       e;
      logic [63:0] cur;
      cur = 64'({if_a.dump_valid, if_a.dump_is_mem, if_a.dump_idx, if_a.dump_data});
      if (!reset) begin
         hold_pend_a = 1'b0;
      end else begin
         if (hold_pend_a) check("a_hold_stable", cur, hold_snap_a);
         hold_pend_a = if_a.dump_valid && !ready_a;
         hold_snap_a = cur;
         if (if_a.dump_valid) begin
            check("a_stall_busy_during_beat", 64'({stall_a, busy_a}), 64'(2'b11));
            check("a_raddr_idle_during_beat", 64'({rf_raddr_a, mem_raddr_a}), 64'(0));
         end
         if (if_a.dump_valid && ready_a) begin
            beats_a++;
            if (exp_a.size() == 0) fail_now("a_extra_beat", "beat accepted with no beat expected");
            else begin
               e = exp_a.pop_front();
               check("a_beat", 64'({if_a.dump_is_mem, if_a.dump_idx, if_a.dump_data}),
                     64'({e.is_mem, e.idx[3:0], e.data[15:0]}));
            end
         end
         if (done_a) begin
            dones_a++;
            check("a_done_queue_empty", 64'(exp_a.size()), 64'(0));
            check("a_done_not_busy", 64'({busy_a, stall_a, if_a.dump_valid}), 64'(0));
            if (exp_done_cyc_a >= 0) check("a_done_cycle", 64'(cycle), 64'(exp_done_cyc_a));
            exp_done_cyc_a = -1;
         end
      end
   end

   task automatic fire_start_a(input bit timed);
      @(posedge clk); #1;
      start_a = 1'b1;
      push_expect_a();
      exp_done_cyc_a = timed ? cycle + A_DONE_LAT : -1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   task automatic wait_dones_a(input int target, input int budget);
      int n = 0;
      while (dones_a < target && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (dones_a < target) fail_now("a_done_timeout", $sformatf("dones=%0d, required %0d", dones_a, target));
   endtask

   // ---------------- instance B: NUM_REGS=4, MEM_DEPTH=64, DATA_WIDTH=32 ----------------
   logic        start_b = 1'b0, bp_en_b = 1'b0, ready_b = 1'b1;
   logic [11:0] pc_b = '0, bp_pc_b = '0;
   logic [1:0]  rf_raddr_b;
   logic [5:0]  mem_raddr_b;
   logic [31:0] rf_rdata_b, mem_rdata_b;
   logic        stall_b, busy_b, done_b;
   logic [31:0] regs_b [B_NR];
   logic [31:0] mem_b  [B_MD];

   cpu_state_dumper_if #(.DATA_WIDTH(32), .IDX_W(6)) if_b ();
   assign if_b.dump_ready = ready_b;

   cpu_state_dumper #(.WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(B_NR), .MEM_DEPTH(B_MD)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .pc(pc_b), .bp_en(bp_en_b), .bp_pc(bp_pc_b),
      .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b), .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b),
      .cpu_stall(stall_b), .dump(if_b), .busy(busy_b), .done(done_b));

   assign rf_rdata_b = regs_b[rf_raddr_b];
   always @(posedge clk) mem_rdata_b <= mem_b[mem_raddr_b];

   beat_t exp_b [$];
   int    beats_b = 0, dones_b = 0, exp_done_cyc_b = -1, last_idx_b = -1;

   always @(negedge clk) begin : mon_b
      beat_t e;
      if (reset) begin
         if (if_b.dump_valid && ready_b) begin
            beats_b++;
            last_idx_b = int'(if_b.dump_idx);
            if (exp_b.size() == 0) fail_now("b_extra_beat", "beat accepted with no beat expected");
            else begin
               e = exp_b.pop_front();
               check("b_beat", 64'({if_b.dump_is_mem, if_b.dump_idx, if_b.dump_data}),
                     64'({e.is_mem, e.idx[5:0], e.data}));
            end
         end
         if (done_b) begin
            dones_b++;
            check("b_done_queue_empty", 64'(exp_b.size()), 64'(0));
            if (exp_done_cyc_b >= 0) check("b_done_cycle", 64'(cycle), 64'(exp_done_cyc_b));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : main
      int trig, pc_bad, d0, b0, n;

      #1;
      check("a_reset_outputs", 64'({stall_a, busy_a, done_a, if_a.dump_valid, if_a.dump_is_mem,
                                    if_a.dump_idx, if_a.dump_data, rf_raddr_a, mem_raddr_a}), 64'(0));
      check("b_reset_outputs", 64'({stall_b, busy_b, done_b, if_b.dump_valid, rf_raddr_b, mem_raddr_b}), 64'(0));
      for (int i = 0; i < A_NR; i++) regs_a[i] = 16'h1000 + 16'(i);
      for (int j = 0; j < A_MD; j++) mem_a[j]  = 16'hA000 + 16'(j);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("a_idle_after_reset", 64'({busy_a, stall_a, if_a.dump_valid, done_a}), 64'(0));

      // 1: manual start, ready held high, exact done latency.
      fire_start_a(1'b1);
      wait_dones_a(1, 200);
      check("t1_beats", 64'(beats_a), 64'(A_NR + A_MD));

      // 2: breakpoint trigger with a stepping PC.
      @(posedge clk); #1;
      pc_clr = 1'b1; bp_pc_a = 12'h014; bp_en_a = 1'b1;
      @(posedge clk); #1;
      pc_clr = 1'b0; cpu_run = 1'b1;
      trig = -1;
      for (int k = 0; k < 40 && trig < 0; k++) begin
         @(negedge clk);
         if (pc_a == bp_pc_a && !busy_a) begin
            trig = cycle;
            push_expect_a();
            exp_done_cyc_a = cycle + A_DONE_LAT;
            check("t2_no_stall_at_hit", 64'(stall_a), 64'(0));
         end
      end
      if (trig < 0) fail_now("t2_bp_timeout", "pc never reached bp_pc");
      @(negedge clk);
      check("t2_stall_next_cycle", 64'({stall_a, busy_a}), 64'(2'b11));
      pc_bad = 0;
      n = 0;
      while (busy_a && n < 200) begin
         if (pc_a != 12'h014) pc_bad++;
         if (n == 40) bp_en_a = 1'b0;
         @(negedge clk);
         n++;
      end
      check("t2_pc_frozen", 64'(pc_bad), 64'(0));
      wait_dones_a(2, 50);
      cpu_run = 1'b0;

      // 3: random ready, same register/DMEM contents.
      ready_rand_a = 1'b1;
      fire_start_a(1'b0);
      wait_dones_a(3, 400);

      // 3b: random ready and random contents.
      for (int i = 0; i < A_NR; i++) regs_a[i] = 16'($urandom);
      for (int j = 0; j < A_MD; j++) mem_a[j]  = 16'($urandom);
      fire_start_a(1'b0);
      wait_dones_a(4, 400);

      // 4: extra start pulse and breakpoint hit while busy are ignored.
      d0 = dones_a;
      b0 = beats_a;
      fire_start_a(1'b0);
      repeat (10) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      bp_pc_a = pc_a;
      bp_en_a = 1'b1;
      repeat (20) @(posedge clk);
      #1 bp_en_a = 1'b0;
      wait_dones_a(d0 + 1, 400);
      repeat (20) @(negedge clk);
      check("t4_one_done", 64'(dones_a - d0), 64'(1));
      check("t4_beat_count", 64'(beats_a - b0), 64'(A_NR + A_MD));
      check("t4_idle_after", 64'(busy_a), 64'(0));

      // 5: reset while mem[5] is held in MEM_OUT.
      ready_rand_a = 1'b0;
      ready_hold_a = 1'b1;
      fire_start_a(1'b0);
      n = 0;
      while (!(if_a.dump_valid && if_a.dump_is_mem && if_a.dump_idx == 4'd4) && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      ready_hold_a = 1'b0;
      n = 0;
      while (!(if_a.dump_valid && if_a.dump_is_mem && if_a.dump_idx == 4'd5) && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (!(if_a.dump_valid && if_a.dump_idx == 4'd5)) fail_now("t5_reach_mem5", "mem[5] beat never presented");
      d0 = dones_a;
      reset = 1'b0;
      #1;
      check("t5_reset_outputs", 64'({stall_a, busy_a, done_a, if_a.dump_valid, if_a.dump_is_mem,
                                     if_a.dump_idx, if_a.dump_data, rf_raddr_a, mem_raddr_a}), 64'(0));
      exp_a.delete();
      exp_done_cyc_a = -1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      ready_hold_a = 1'b1;
      repeat (4) @(negedge clk);
      check("t5_no_done_after_abort", 64'(dones_a), 64'(d0));
      fire_start_a(1'b1);
      wait_dones_a(d0 + 1, 200);

      // 6: wide/deep configuration on instance B.
      for (int i = 0; i < B_NR; i++) regs_b[i] = $urandom;
      for (int j = 0; j < B_MD; j++) mem_b[j]  = $urandom;
      @(posedge clk); #1;
      start_b = 1'b1;
      for (int i = 0; i < B_NR; i++) exp_b.push_back('{1'b0, i, regs_b[i]});
      for (int j = 0; j < B_MD; j++) exp_b.push_back('{1'b1, j, mem_b[j]});
      exp_done_cyc_b = cycle + B_DONE_LAT;
      @(posedge clk); #1;
      start_b = 1'b0;
      n = 0;
      while (dones_b < 1 && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      if (dones_b < 1) fail_now("b_done_timeout", "no done from wide instance");
      check("t6_beats", 64'(beats_b), 64'(B_NR + B_MD));
      check("t6_last_idx", 64'(last_idx_b), 64'(B_MD - 1));
      check("t6_one_done", 64'(dones_b), 64'(1));

      repeat (5) @(negedge clk);
      check("a_queue_drained", 64'(exp_a.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
